// File: rtl/afe_config_sequencer_if.sv
// Command-ROM and SPI pin bundle between the AFE config sequencer
// (master) and the ROM / AFE devices (slave).
interface afe_config_sequencer_if #(
  parameter int NUM_DEV = 2,
  parameter int ROM_AW  = 8,
  parameter int ROM_DW  = 27
);
  logic [ROM_AW-1:0]  rom_addr;
  logic [ROM_DW-1:0]  rom_data;
  logic               miso;
  logic               sclk;
  logic               mosi;
  logic [NUM_DEV-1:0] cs_n;

  modport master (
    output rom_addr, sclk, mosi, cs_n,
    input  rom_data, miso
  );

  modport slave (
    input  rom_addr, sclk, mosi, cs_n,
    output rom_data, miso
  );
endinterface

// File: rtl/afe_config_sequencer.sv
// Holds AFEs in reset, streams ROM-held SPI register writes with optional
// readback verify and retry, then pulses sync and flags completion.
module afe_config_sequencer #(
  parameter int NUM_DEV      = 2,
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 16,
  parameter int ROM_AW       = 8,
  parameter int RESET_CYCLES = 64,
  parameter int SCLK_DIV     = 2,
  parameter int SYNC_CYCLES  = 4,
  parameter int MAX_RETRY    = 3,
  localparam int DEV_W  = ($clog2(NUM_DEV + 1) > 1) ? $clog2(NUM_DEV + 1) : 1,
  localparam int ROM_DW = 2 + DEV_W + ADDR_W + DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  afe_config_sequencer_if.master bus,
  output logic              device_reset,
  output logic              pdn,
  output logic              device_sync,
  output logic              busy,
  output logic              configure_done,
  output logic              error,
  output logic [ROM_AW-1:0] error_index
);
  localparam int F    = 1 + ADDR_W + DATA_W;
  localparam int C1   = (RESET_CYCLES > SYNC_CYCLES) ? RESET_CYCLES : SYNC_CYCLES;
  localparam int CMAX = (C1 > 2 * SCLK_DIV) ? C1 : 2 * SCLK_DIV;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int PW   = $clog2(2 * SCLK_DIV);
  localparam int BW   = $clog2(F);
  localparam int TW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [3:0] {
    S_HOLD, S_FETCH, S_WAIT, S_LAUNCH, S_SHIFT, S_CSUP,
    S_GAP, S_CHECK, S_NEXT, S_SYNC, S_DONE, S_FAIL
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [PW-1:0]      ph_q;
  logic [BW-1:0]      bidx_q;
  logic [F-1:0]       sh_q;
  logic [DATA_W-1:0]  rd_q;
  logic [ROM_DW-1:0]  ent_q;
  logic               is_rd_q;
  logic [TW-1:0]      retry_q;
  logic [ROM_AW-1:0]  rom_addr_q;
  logic               rst_q;
  logic               sclk_q;
  logic [NUM_DEV-1:0] cs_n_q;
  logic               sync_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [ROM_AW-1:0]  err_idx_q;

  logic [DATA_W-1:0]  e_data;
  logic [ADDR_W-1:0]  e_addr;
  logic [DEV_W-1:0]   e_dev;
  logic               e_vfy;
  logic               e_last;
  logic               bcast;
  logic [NUM_DEV-1:0] sel_n;
  logic [F-1:0]       frame;

  assign e_data = ent_q[DATA_W-1:0];
  assign e_addr = ent_q[DATA_W +: ADDR_W];
  assign e_dev  = ent_q[DATA_W+ADDR_W +: DEV_W];
  assign e_vfy  = ent_q[ROM_DW-2];
  assign e_last = ent_q[ROM_DW-1];
  assign bcast  = (e_dev >= DEV_W'(NUM_DEV));
  assign frame  = is_rd_q ? {1'b1, e_addr, {DATA_W{1'b0}}}
                          : {1'b0, e_addr, e_data};

  always_comb begin
    sel_n = '1;
    for (int i = 0; i < NUM_DEV; i++) begin
      sel_n[i] = ~(bcast | (e_dev == DEV_W'(i)));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_HOLD;
      cnt_q      <= '0;
      ph_q       <= '0;
      bidx_q     <= '0;
      sh_q       <= '0;
      rd_q       <= '0;
      ent_q      <= '0;
      is_rd_q    <= 1'b0;
      retry_q    <= '0;
      rom_addr_q <= '0;
      rst_q      <= 1'b1;
      sclk_q     <= 1'b0;
      cs_n_q     <= '1;
      sync_q     <= 1'b0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (cnt_q == CW'(RESET_CYCLES - 1)) begin
            rst_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_FETCH;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_FETCH: state_q <= S_WAIT;
        S_WAIT: begin
          ent_q   <= bus.rom_data;
          is_rd_q <= 1'b0;
          state_q <= S_LAUNCH;
        end
        S_LAUNCH: begin
          sh_q    <= frame;
          cs_n_q  <= sel_n;
          sclk_q  <= 1'b0;
          ph_q    <= '0;
          bidx_q  <= '0;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          // readback bits are captured on the clk where sclk rises
          if (ph_q == PW'(SCLK_DIV - 1)) begin
            sclk_q <= 1'b1;
            if (is_rd_q && bidx_q >= BW'(1 + ADDR_W)) begin
              rd_q <= {rd_q[DATA_W-2:0], bus.miso};
            end
          end
          if (ph_q == PW'(2 * SCLK_DIV - 1)) begin
            ph_q   <= '0;
            sclk_q <= 1'b0;
            if (bidx_q == BW'(F - 1)) begin
              state_q <= S_CSUP;
            end else begin
              bidx_q <= bidx_q + BW'(1);
              sh_q   <= {sh_q[F-2:0], 1'b0};
            end
          end else begin
            ph_q <= ph_q + PW'(1);
          end
        end
        S_CSUP: begin
          cs_n_q  <= '1;
          sh_q    <= '0;
          cnt_q   <= '0;
          state_q <= S_GAP;
        end
        S_GAP: begin
          if (cnt_q == CW'(2 * SCLK_DIV - 1)) begin
            cnt_q <= '0;
            if (is_rd_q) begin
              state_q <= S_CHECK;
            end else if (e_vfy && !bcast) begin
              is_rd_q <= 1'b1;
              state_q <= S_LAUNCH;
            end else begin
              state_q <= S_NEXT;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_CHECK: begin
          if (rd_q == e_data) begin
            state_q <= S_NEXT;
          end else if (retry_q < TW'(MAX_RETRY)) begin
            retry_q <= retry_q + TW'(1);
            is_rd_q <= 1'b0;
            state_q <= S_LAUNCH;
          end else begin
            err_q     <= 1'b1;
            err_idx_q <= rom_addr_q;
            busy_q    <= 1'b0;
            state_q   <= S_FAIL;
          end
        end
        S_NEXT: begin
          retry_q <= '0;
          // an all-ones address stops the walk even without a last flag
          if (e_last || (&rom_addr_q)) begin
            sync_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_SYNC;
          end else begin
            rom_addr_q <= rom_addr_q + ROM_AW'(1);
            state_q    <= S_FETCH;
          end
        end
        S_SYNC: begin
          if (cnt_q == CW'(SYNC_CYCLES - 1)) begin
            sync_q  <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE, S_FAIL: begin
          if (start) begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            rom_addr_q <= '0;
            rst_q      <= 1'b1;
            cnt_q      <= '0;
            retry_q    <= '0;
            state_q    <= S_HOLD;
          end
        end
        default: state_q <= S_HOLD;
      endcase
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.sclk       = sclk_q;
  assign bus.mosi       = sh_q[F-1];
  assign bus.cs_n       = cs_n_q;
  assign device_reset   = rst_q;
  assign pdn            = ~done_q;
  assign device_sync    = sync_q;
  assign busy           = busy_q;
  assign configure_done = done_q;
  assign error          = err_q;
  assign error_index    = err_idx_q;
endmodule

// File: doc/afe_config_sequencer.md
Name: afe_config_sequencer

Overview:
- Parametrised successor to the single-device AFE configuration path. Holds the AFEs in reset, then walks an external command ROM and shifts one SPI frame per entry to one of NUM_DEV devices through per-device chip selects.
- Optionally reads each written register back and retries on mismatch.
- On success, pulses sync, then raises configure_done. Sits between the board reset/clock and the AFE control pins; the receive datapath waits on configure_done.

Parameters:
- NUM_DEV, 2, number of AFE devices (cs_n width), ≥1.
- ADDR_W, 7, register address bits.
- DATA_W, 16, register data bits.
- ROM_AW, 8, command ROM address bits; ROM depth = 2^ROM_AW.
- RESET_CYCLES, 64, clk cycles device_reset is held high.
- SCLK_DIV, 2, sclk half-period in clk cycles, ≥1.
- SYNC_CYCLES, 4, device_sync pulse width in clk cycles.
- MAX_RETRY, 3, extra write+verify attempts after a mismatch.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  restart pulse; honoured only when busy=0.
- rom_addr  out  ROM_AW  command ROM address.
- rom_data  in  2+DEV_W+ADDR_W+DATA_W  ROM word {last, verify, dev_sel[DEV_W], addr, data}, DEV_W=max(1,clog2(NUM_DEV+1)); valid 1 clk after rom_addr changes.
- miso  in  1  shared serial readback.
- sclk  out  1  serial clock, idle low.
- cs_n  out  NUM_DEV  active-low chip selects.
- mosi  out  1  serial data.
- device_reset  out  1  AFE hardware reset, active high.
- pdn  out  1  AFE power-down; equals ~configure_done.
- device_sync  out  1  sync pulse.
- busy  out  1  sequence in progress.
- configure_done  out  1  all entries written and verified.
- error  out  1  verify failed after retries.
- error_index  out  ROM_AW  ROM index of the failing entry.

Behaviour:
- Reset values: state RESET_HOLD, device_reset=1, pdn=1, cs_n all 1, sclk=0, mosi=0, device_sync=0, busy=1, configure_done=0, error=0, error_index=0, rom_addr=0, retry count 0.
- Reset asserted mid-frame aborts immediately to the reset values; no partial frame is completed.
- RESET_HOLD: device_reset stays 1 for exactly RESET_CYCLES clks after reset release, then drops to 0. State moves to FETCH.
- FETCH/WAIT_ROM: drive rom_addr, wait 1 clk, latch rom_data.
- Frame format: F=1+ADDR_W+DATA_W bits, MSB first: {rw, addr, data}, with rw=0 for write and 1 for read.
- Frame timing:
  - Selected cs_n falls at bit-period start.
  - Each bit period is 2·SCLK_DIV clks: mosi updates at period start, sclk is low for the first SCLK_DIV clks and high for the second SCLK_DIV.
  - cs_n rises 1 clk after the last period ends, with sclk already 0.
  - Inter-frame gap: cs_n all high for ≥2·SCLK_DIV clks.
- Device selection: dev_sel < NUM_DEV selects that cs_n bit alone. dev_sel ≥ NUM_DEV is a broadcast: all cs_n low, and the verify bit is ignored.
- Verify (verify=1, non-broadcast):
  - After the write frame and gap, send a read frame with the same addr; its data bits are mosi=0.
  - miso is sampled on the clk where sclk rises, for the DATA_W data bits only.
  - CHECK compares the captured value to data.
  - Match → NEXT.
  - Mismatch with retry < MAX_RETRY → increment retry and resend the write then the read.
  - Otherwise → FAIL.
  - The retry count clears on entering NEXT.
- NEXT:
  - last=1, or rom_addr = 2^ROM_AW−1 (wrap guard) → SYNC.
  - Otherwise rom_addr+1 → FETCH.
- SYNC: device_sync=1 for exactly SYNC_CYCLES clks → DONE.
- DONE: configure_done=1, pdn=0, busy=0.
- FAIL: error=1, error_index=failing rom_addr, busy=0, configure_done=0, no sync pulse, cs_n all 1.
- start with busy=0 (DONE or FAIL):
  - Next clk: clear error and configure_done, set busy=1 and rom_addr=0, enter RESET_HOLD.
  - start with busy=1 is ignored.
- MISO is ignored outside read-frame data bits.

Test Plan:
- Power-up: reset released → device_reset high exactly 64 clks; rom_addr=0 fetched. Entry {last=1,verify=0,dev=1,addr=0x05,data=0xA5C3} → cs_n=2'b01, mosi frame 0_0000101_1010010111000011 (24 bits, 96 clks), sync high 4 clks, configure_done=1, pdn=0.
- Verify pass: entry verify=1, dev=0, miso model returns the written data 0x1234 → one write frame then one read frame with rw=1, no retry, done.
- Verify fail: miso always returns 0x0000 for data 0x00FF → 4 write+read pairs (1+MAX_RETRY), then error=1, error_index = entry index, configure_done=0, no device_sync.
- Broadcast and wrap: dev_sel=2 → cs_n=2'b00 and no read frame. With ROM_AW=2 and no last bit set, the sequence stops after entry 3 and goes to SYNC/DONE.
- Restart: start in DONE → configure_done drops next clk, device_reset reasserts 64 clks, sequence reruns. start pulsed while busy=1 → no effect.
- Mid-frame reset: assert reset at bit 10 of a frame → cs_n all 1, sclk=0, device_reset=1 the same cycle. After release the sequence restarts from rom_addr 0.
